// File: rtl/usrt_pkg.sv
// rtl/usrt_pkg.sv - shared USRT bridge types and defaults
package usrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    localparam int APB_TIMEOUT_DEFAULT = 255;
    localparam int USRT_DATA_W         = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS-phase wait counter
module apb_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic pClk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired_o = (count_q == CNT_W'(TIMEOUT));

    // Holds at TIMEOUT so the expired flag can never be lost to a wrap.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge pClk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - single-outstanding APB requester with wait timeout
module apb_initiator
    import usrt_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = USRT_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic              pClk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              pSelect,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddress,
    output logic [DATA_W-1:0] pWData,
    input  logic [DATA_W-1:0] pRData,
    input  logic              pReady,
    input  logic              pSlvErr,
    output logic              busy
);

    apb_state_t        state_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic              expired;

    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .pClk     (pClk),
        .rst      (rst),
        .clear_i  (state_q == SETUP),
        .inc_i    ((state_q == ACCESS) && !pReady),
        .expired_o(expired)
    );

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign pSelect     = (state_q == SETUP) || (state_q == ACCESS);
    assign pEnable     = (state_q == ACCESS);
    assign busy        = (state_q != IDLE);
    assign pWrite      = pwrite_q;
    assign pAddress    = paddr_q;
    assign pWData      = pwdata_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge pClk) begin
        if (rst) begin
            state_q       <= IDLE;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    // A ready on the final allowed cycle still completes normally.
                    if (pReady) begin
                        rsp_rdata_q   <= (pwrite_q || pSlvErr) ? '0 : pRData;
                        rsp_err_q     <= pSlvErr;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end else if (expired) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_initiator.sv
// tb/tb_apb_initiator.sv - self-checking bench for apb_initiator
module tb_apb_initiator;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        pSelect, pEnable, pWrite;
    logic [31:0] pAddress;
    logic [7:0]  pWData, pRData;
    logic        pReady, pSlvErr, busy;

    int errors = 0;
    int checks = 0;

    apb_initiator #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(T)) dut (
        .pClk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .pSelect(pSelect), .pEnable(pEnable), .pWrite(pWrite),
        .pAddress(pAddress), .pWData(pWData), .pRData(pRData),
        .pReady(pReady), .pSlvErr(pSlvErr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wd;
        int          waits;
        logic        se;
        logic [7:0]  rd;
        logic [7:0]  exp_rd;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a slave that raises ready after 'waits' wait cycles, judged against the timeout budget.
    function automatic void model(input logic wr, input int waits, input logic se, input logic [7:0] rd,
                                  output logic [7:0] e_rd, output logic e_err, output logic e_to,
                                  output int e_lat, output int e_acc);
        if (waits > T) begin
            e_rd = 8'h00; e_err = 1'b1; e_to = 1'b1; e_lat = 3 + T; e_acc = T + 1;
        end else begin
            e_rd = (wr || se) ? 8'h00 : rd; e_err = se; e_to = 1'b0;
            e_lat = 3 + waits; e_acc = waits + 1;
        end
    endfunction

    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                           input int waits, input logic se, input logic [7:0] rd,
                           output int lat, output logic [7:0] o_rd, output logic o_err,
                           output logic o_to, output int acc, output int sel_n, output bit ok);
        bit done;
        ok = 1; acc = 0; sel_n = 0; lat = 0; done = 0;
        @(negedge clk);
        if (cmd_ready !== 1'b1) ok = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = 8'($urandom); cmd_write = ~wr;
        lat = 1;
        for (int g = 0; g < 60 && !done; g++) begin
            if (rsp_valid === 1'b1) begin
                done = 1;
            end else begin
                if (pSelect === 1'b1) begin
                    sel_n++;
                    if (pAddress !== addr || pWrite !== wr || pWData !== wd) ok = 0;
                end
                if (pSelect === 1'b1 && pEnable === 1'b1) begin
                    acc++;
                    pReady = (acc - 1 == waits); pSlvErr = se; pRData = rd;
                end else begin
                    pReady = 0; pSlvErr = 1'($urandom); pRData = 8'($urandom);
                end
                @(negedge clk);
                lat++;
            end
        end
        if (!done) lat = -1;
        pReady = 0;
        o_rd = rsp_rdata; o_err = rsp_err; o_to = rsp_timeout;
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_rdata !== o_rd || rsp_err !== o_err ||
            rsp_timeout !== o_to || pSelect !== 1'b0) ok = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) ok = 0;
    endtask

    task automatic run_one(input string tag, input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                           input int waits, input logic se, input logic [7:0] rd,
                           input logic [7:0] e_rd, input logic e_err, input logic e_to, input int e_lat);
        int lat, acc, sel_n, e_lat2, e_acc;
        logic [7:0] o_rd, m_rd;
        logic o_err, o_to, m_err, m_to;
        bit ok;
        model(wr, waits, se, rd, m_rd, m_err, m_to, e_lat2, e_acc);
        do_xfer(wr, addr, wd, waits, se, rd, lat, o_rd, o_err, o_to, acc, sel_n, ok);
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_rdata"}, o_rd, e_rd);
        check({tag, "_err"}, o_err, e_err);
        check({tag, "_timeout"}, o_to, e_to);
        check({tag, "_access_cycles"}, acc, e_acc);
        check({tag, "_select_cycles"}, sel_n, e_acc + 1);
        check({tag, "_protocol"}, ok, 1);
    endtask

    initial begin
        int bad;
        logic [7:0] m_rd;
        logic m_err, m_to;
        int m_lat, m_acc;

        vecs[0] = '{1'b1, 32'h0000_0010, 8'hA5, 0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h0000_0004, 8'h00, 3, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 6};
        vecs[2] = '{1'b0, 32'h0000_0008, 8'h00, 0, 1'b1, 8'h99, 8'h00, 1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 32'h0000_000C, 8'h00, 9, 1'b0, 8'h55, 8'h00, 1'b1, 1'b1, 7};
        vecs[4] = '{1'b0, 32'h1234_5678, 8'h00, 4, 1'b0, 8'hC3, 8'hC3, 1'b0, 1'b0, 7};
        vecs[5] = '{1'b1, 32'hDEAD_BEEF, 8'h5A, 2, 1'b1, 8'h77, 8'h00, 1'b1, 1'b0, 5};

        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; pRData = 0; pReady = 0; pSlvErr = 0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_outputs", {rsp_valid, rsp_err, rsp_timeout, pSelect, pEnable, pWrite, busy}, 0);
        check("reset_paddr", pAddress, 0);
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits,
                    vecs[i].se, vecs[i].rd, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_to,
                    vecs[i].exp_lat);
        end

        for (int i = 0; i < 20; i++) begin
            logic wr, se;
            logic [31:0] addr;
            logic [7:0] wd, rd;
            int waits;
            wr = 1'($urandom); se = ($urandom_range(0, 3) == 0);
            addr = $urandom; wd = 8'($urandom); rd = 8'($urandom);
            waits = $urandom_range(0, T + 2);
            model(wr, waits, se, rd, m_rd, m_err, m_to, m_lat, m_acc);
            run_one($sformatf("rand%0d", i), wr, addr, wd, waits, se, rd, m_rd, m_err, m_to, m_lat);
        end

        // Response backpressure with a second command waiting behind it.
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h100; cmd_wdata = 8'h00;
        pReady = 1; pRData = 8'h5A; pSlvErr = 0;
        @(negedge clk);
        cmd_write = 1; cmd_addr = 32'h200; cmd_wdata = 8'h11;
        for (int g = 0; g < 10 && rsp_valid !== 1'b1; g++) @(negedge clk);
        check("bp_first_rsp", rsp_valid, 1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || pSelect !== 1'b0 ||
                pEnable !== 1'b0 || rsp_rdata !== 8'h5A || rsp_err !== 1'b0) bad++;
            @(negedge clk);
        end
        check("bp_hold_stable", bad, 0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("bp_idle_gap", {cmd_ready, pSelect, rsp_valid}, 3'b100);
        @(negedge clk);
        cmd_valid = 0;
        check("bp_second_setup", {pSelect, pEnable, pWrite}, 3'b101);
        check("bp_second_addr", pAddress, 32'h200);
        @(negedge clk);
        @(negedge clk);
        check("bp_second_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0; pReady = 0;

        // Reset pulse during the second wait cycle of ACCESS.
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'hABCD_0000;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("rst_mid_in_access", {pSelect, pEnable}, 2'b11);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_mid_outputs", {pSelect, pEnable, rsp_valid, busy, cmd_ready}, 5'b00001);
        check("rst_mid_paddr", pAddress, 0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("rst_mid_no_response", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
